arb2_1_rr: RTL and testbench
============================

Name: arb2_1_rr

Overview:
- Two-requester round-robin arbiter that sits directly upstream of mux2x1.
- It generates the mux select: sel drives the mux enb port, where 1 selects in1 and 0 selects in2.
- It returns per-source grants so that only one producer owns the mux output at a time.
- A hold-time limit with a forced-release timeout prevents either source from starving the other.

Parameters:
HOLD_MAX  8  maximum consecutive cycles a grant may be held before forced release (legal range 2..2**CNT_W-1)
CNT_W     4  width of the internal hold counter

Ports:
clk      input   1  single system clock, all logic on rising edge
rst      input   1  synchronous, active-high reset
req1     input   1  source 1 (mux in1) requests ownership
req2     input   1  source 2 (mux in2) requests ownership
done1    input   1  source 1 releases grant (single-cycle pulse, honoured only while gnt1=1)
done2    input   1  source 2 releases grant (single-cycle pulse, honoured only while gnt2=1)
gnt1     output  1  source 1 owns the mux
gnt2     output  1  source 2 owns the mux
sel      output  1  mux select to mux2x1 enb: 1 = in1, 0 = in2
busy     output  1  a grant is active (gnt1 | gnt2)
timeout  output  1  one-cycle pulse when a grant is force-released at HOLD_MAX

Behaviour:
- All outputs are registered; every output changes only on a rising clk edge.
- Reset (rst=1 at the edge) sets: state=IDLE, gnt1=0, gnt2=0, sel=0, busy=0, timeout=0, hold_cnt=0, last=2. With last=2, source 1 wins the first contention.
- Reset overrides everything, including mid-grant. Grants drop at the same edge with no timeout pulse.
- States: IDLE, G1, G2. At most one of gnt1/gnt2 is high at any time; gnt1=1 iff state=G1, gnt2=1 iff state=G2.
- IDLE:
  - Only req1 high -> G1.
  - Only req2 high -> G2.
  - Both high -> grant the source that is not `last`.
  - Neither high -> stay in IDLE.
  - Grant appears one cycle after the sampled request (1-cycle latency).
- G1 / G2 release conditions:
  - (a) doneX=1, or
  - (b) reqX=0, or
  - (c) hold_cnt == HOLD_MAX-1. Condition (c) also pulses timeout=1 for the cycle after the release edge.
- Conditions (a), (b) and (c) are evaluated in the same cycle. If (c) coincides with (a) or (b), the release is treated as normal and timeout stays 0.
- On release:
  - last = releasing source.
  - If the other source's request is high in the release cycle, go directly to the other grant state (no idle bubble).
  - Otherwise go to IDLE.
  - The releasing source is never re-granted back-to-back; it must pass through IDLE or the other grant first.
- hold_cnt:
  - Cleared on every state change.
  - Increments each cycle in G1/G2.
  - Saturates at HOLD_MAX-1.
- sel:
  - Set to 1 on entry to G1 and to 0 on entry to G2, in the same edge as the grant.
  - Holds its last value in IDLE, so the mux output stays stable.
- busy = registered (next state != IDLE).
- doneX while gntX=0 is ignored.
- A request dropping in IDLE before it is granted is not remembered.

Test Plan:
- Reset, then req1=1 only -> gnt1=1, sel=1, busy=1 exactly one clk later; done1 pulse -> gnt1=0, busy=0 the next clk, with sel remaining 1.
- After reset, req1 and req2 rise in the same cycle -> gnt1 first. On done1 with req2 still high -> gnt2=1, sel=0 on the very next edge, with no cycle where busy=0.
- req2 held high with no done2, HOLD_MAX=8 -> gnt2 stays high for 8 cycles, then drops; timeout=1 for exactly one cycle; if req1=1, gnt1 follows immediately.
- Both requesters continuously high, each pulsing done after 3 cycles of grant -> grants alternate 1,2,1,2 with no source granted twice in a row.
- rst asserted for one cycle while gnt2=1 and hold_cnt=5 -> next edge: all outputs 0, sel=0. With req1 and req2 both held high, gnt1 is asserted one cycle after rst deasserts.
- done1 pulsed while gnt2=1 and req2=1 -> ignored, gnt2 remains 1; done2 coincident with hold_cnt=HOLD_MAX-1 -> release with timeout=0.

Source files
------------

// File: rtl/arb2_1_rr.sv
// Two-requester round-robin arbiter that drives the mux2x1 select.
// A grant is limited to HOLD_MAX cycles; a forced release pulses timeout.
module arb2_1_rr #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  input  logic done1,
  input  logic done2,
  output logic gnt1,
  output logic gnt2,
  output logic sel,
  output logic busy,
  output logic timeout
);

  // One-hot grant encoding lets gnt1/gnt2/busy come straight off the state flops.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G1   = 2'b01,
    G2   = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last1_q, last1_d;   // 1 = source 1 released last, 0 = source 2
  logic             sel_q, sel_d;
  logic             timeout_q, timeout_d;
  logic             hold_at_max;

  assign hold_at_max = (hold_cnt_q == CNT_LAST);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    last1_d   = last1_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req1 && (!req2 || !last1_q)) state_d = G1;
        else if (req2)                   state_d = G2;
      end
      G1: begin
        if (done1 || !req1 || hold_at_max) begin
          timeout_d = hold_at_max && !done1 && req1;
          last1_d   = 1'b1;
          state_d   = req2 ? G2 : IDLE;
        end
      end
      G2: begin
        if (done2 || !req2 || hold_at_max) begin
          timeout_d = hold_at_max && !done2 && req2;
          last1_d   = 1'b0;
          state_d   = req1 ? G1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // sel follows the grant on entry and holds through IDLE so the mux output stays put.
    sel_d = sel_q;
    if (state_d == G1)      sel_d = 1'b1;
    else if (state_d == G2) sel_d = 1'b0;

    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q)                    hold_cnt_d = '0;
    else if (state_q != IDLE && !hold_at_max)  hold_cnt_d = hold_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last1_q    <= 1'b0;
      sel_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last1_q    <= last1_d;
      sel_q      <= sel_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt1    = state_q[0];
  assign gnt2    = state_q[1];
  assign busy    = |state_q;
  assign sel     = sel_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb2_1_rr.sv
// Self-checking bench for arb2_1_rr: directed scenarios then random traffic,
// all compared against an ownership-level reference model.
module tb_arb2_1_rr;

  localparam int HOLD_MAX = 8;

  logic clk = 1'b0;
  logic rst, req1, req2, done1, done2;
  logic gnt1, gnt2, sel, busy, timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the mux, how many cycles it has owned it, who released last.
  int m_owner = 0;
  int m_held  = 0;
  int m_last  = 2;
  bit m_sel   = 1'b0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  arb2_1_rr #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .done1(done1), .done2(done2),
    .gnt1(gnt1), .gnt2(gnt2), .sel(sel), .busy(busy), .timeout(timeout)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic grant_to(input int who);
    m_owner = who;
    m_held  = 1;
    m_sel   = (who == 1);
  endtask

  task automatic model_step(input bit r, input bit q1, input bit q2, input bit d1, input bit d2);
    bit my_req, my_done, other_req;
    m_to = 1'b0;
    if (r) begin
      m_owner = 0; m_held = 0; m_last = 2; m_sel = 1'b0;
    end else if (m_owner == 0) begin
      if (q1 && q2)  grant_to(m_last == 1 ? 2 : 1);
      else if (q1)   grant_to(1);
      else if (q2)   grant_to(2);
    end else begin
      my_req    = (m_owner == 1) ? q1 : q2;
      my_done   = (m_owner == 1) ? d1 : d2;
      other_req = (m_owner == 1) ? q2 : q1;
      if (my_done || !my_req || m_held >= HOLD_MAX) begin
        m_to   = (m_held >= HOLD_MAX) && !my_done && my_req;
        m_last = m_owner;
        if (other_req) grant_to(3 - m_owner);
        else begin m_owner = 0; m_held = 0; end
      end else begin
        m_held++;
      end
    end
  endtask

  // Drive inputs between edges, let the DUT and model both take the edge, compare 1 time unit later.
  task automatic step(input bit r, input bit q1, input bit q2, input bit d1, input bit d2);
    rst = r; req1 = q1; req2 = q2; done1 = d1; done2 = d2;
    @(posedge clk);
    model_step(r, q1, q2, d1, d2);
    #1;
    check("gnt1",    gnt1,    m_owner == 1);
    check("gnt2",    gnt2,    m_owner == 2);
    check("sel",     sel,     m_sel);
    check("busy",    busy,    m_owner != 0);
    check("timeout", timeout, m_to);
    check("one_hot", gnt1 && gnt2, 1'b0);
  endtask

  initial begin
    int gnt2_cycles, to_pulses, last_grant, prev_owner, obs_owner, guard;
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; done1 = 1'b0; done2 = 1'b0;
    #2;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_sel",  sel,  1'b0);

    // Single requester, one-cycle latency, done releases, sel holds in IDLE
    step(0, 1, 0, 0, 0);
    check("t1_gnt1", gnt1, 1'b1);
    check("t1_sel",  sel,  1'b1);
    step(0, 1, 0, 1, 0);
    check("t1_rel_busy", busy, 1'b0);
    check("t1_rel_sel",  sel,  1'b1);

    // Simultaneous requests after reset: source 1 first, then seamless handover
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    check("t2_first_gnt1", gnt1, 1'b1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    check("t2_gnt2", gnt2, 1'b1);
    check("t2_sel",  sel,  1'b0);
    check("t2_busy", busy, 1'b1);

    // Forced release after HOLD_MAX cycles; source 1 takes over immediately
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    gnt2_cycles = gnt2 ? 1 : 0;
    to_pulses   = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, i >= 4, 1, 0, 0);
      if (gnt2) gnt2_cycles++;
      if (timeout) begin
        to_pulses++;
        check("t3_handover_gnt1", gnt1, 1'b1);
      end
    end
    check("t3_hold_len_8", gnt2_cycles == HOLD_MAX, 1'b1);
    check("t3_one_timeout", to_pulses == 1, 1'b1);

    // Both requesting, each releasing after 3 cycles: strict alternation
    step(1, 0, 0, 0, 0);
    last_grant = 0;
    prev_owner = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, (m_owner == 1) && (m_held == 3), (m_owner == 2) && (m_held == 3));
      obs_owner = gnt1 ? 1 : (gnt2 ? 2 : 0);
      if (obs_owner != 0 && obs_owner != prev_owner) begin
        if (last_grant != 0) check("t4_no_repeat", obs_owner == last_grant, 1'b0);
        last_grant = obs_owner;
      end
      prev_owner = obs_owner;
    end

    // Reset mid-grant (hold count 5), then source 1 wins after reset
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check("t5_rst_gnt2",    gnt2,    1'b0);
    check("t5_rst_timeout", timeout, 1'b0);
    check("t5_rst_sel",     sel,     1'b0);
    step(0, 1, 1, 0, 0);
    check("t5_gnt1_after_rst", gnt1, 1'b1);

    // done1 ignored during gnt2; done2 coinciding with the hold limit is a normal release
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    check("t6_done1_ignored", gnt2, 1'b1);
    guard = 0;
    while (m_held < HOLD_MAX && guard < 20) begin
      step(0, 0, 1, 0, 0);
      guard++;
    end
    check("t6_reached_limit", m_held == HOLD_MAX && gnt2, 1'b1);
    step(0, 0, 1, 0, 1);
    check("t6_no_timeout", timeout, 1'b0);
    check("t6_released",   gnt2,    1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 150) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 6) == 0, ($urandom % 6) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
